adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
- Shares one 32-bit adder datapath between NUM_REQ independent requesters.
- Arbitration is round-robin; each requester uses a valid/ready handshake.
- Operands are captured, the sum is computed, and a registered result is returned with the ID of the requester that issued it.
- Sits between client blocks and the adder instance; the adder itself is unchanged.

Parameters:
- N, 32, operand/sum width in bits.
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of requester ID.
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept strobe (one-hot or zero)
- req_a  in  NUM_REQ*N  packed operand A; requester i uses bits [i*N +: N]
- req_b  in  NUM_REQ*N  packed operand B, same packing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  ID_W  requester that issued the result
- rsp_sum  out  N  a+b mod 2^N
- rsp_carry  out  1  carry out of bit N-1
- rsp_of  out  1  signed overflow
- busy  out  1  high whenever state != IDLE
- ops_done  out  CNT_W  count of completed responses

Behaviour:
- Reset: rst_n low asynchronously forces the following, regardless of clk:
  - state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, rsp_of=0, busy=0, ops_done=0.
  - Any in-flight operation is discarded and no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, grant the first valid requester searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[grant] is driven high combinationally in this cycle; the transfer occurs on that edge.
  - Operands are latched into op_a/op_b and grant into op_id; next state is EXEC.
  - If no req_valid is high, stay in IDLE with req_ready all zero.
- EXEC:
  - The adder is fed from op_a/op_b.
  - At end of cycle, register sum/carry/overflow into the rsp_* outputs and set rsp_valid=1; next state is RESP.
- RESP:
  - rsp_valid=1, and all rsp_* outputs are held stable until rsp_ready=1.
  - On the rsp_valid&rsp_ready edge: rsp_valid is cleared, ops_done increments (wrapping 2^CNT_W-1 -> 0), rr_ptr = op_id+1 mod NUM_REQ, and next state is IDLE.
- req_ready is zero in EXEC and RESP. A requester keeps req_valid and its operands stable until it sees req_ready.
- Latency:
  - Request accepted at edge T -> rsp_valid high after edge T+1.
  - With rsp_ready held high, the minimum issue interval is 3 cycles.
- Arithmetic:
  - sum = (a+b)[N-1:0]; carry = (a+b)[N].
  - of = (a[N-1]==b[N-1]) && (sum[N-1]!=a[N-1]).
- Fairness: the requester just served has lowest priority in the next arbitration. With all requesters continuously valid, grants follow 0,1,2,..,NUM_REQ-1,0.
- Simultaneous events:
  - A req_valid that drops in the same cycle the arbiter evaluates is simply not granted; no glitch, because the grant is based on the current-cycle req_valid.
  - A new request arriving while in RESP waits; it is not buffered.
- rsp_ready held low indefinitely: the block stays in RESP, busy stays high, and no requester is accepted.

Decomposition:
- Shared package holds:
  - constants ST_IDLE, ST_EXEC, ST_RESP (2-bit encoding);
  - N default;
  - function rr_pick(valid, ptr) returning the grant index plus a found flag.
- One sub-module, adder_core (N): combinational a, b -> sum, carry, of. It wraps whichever adder architecture is selected, so the arbiter stays architecture-agnostic.

Test Plan:
- Single op:
  - Stimulus: req 0, a=0x5DF92D16, b=0x33C3D1E3, rsp_ready=1.
  - Response: req_ready[0] pulse; rsp_valid 2 cycles later with rsp_id=0, sum=0x91BCFEF9, carry=0, of=1; ops_done=1.
- Negative overflow:
  - Stimulus: req 2, a=0x93306CEE, b=0x834DC31F.
  - Response: rsp_id=2, sum=0x167E300D, carry=1, of=1. Then a=0xC0000000, b=0x80000000 -> sum=0x40000000, carry=1, of=1.
- Round-robin:
  - Stimulus: all 4 req_valid high continuously after reset, each with a=i, b=0x10.
  - Response: grant order 0,1,2,3,0; sums 0x10,0x11,0x12,0x13; each requester served once per 4 operations.
- Backpressure:
  - Stimulus: rsp_ready low for 5 cycles during RESP while req 1 is valid.
  - Response: rsp_* stable, req_ready=0, busy=1; the ready edge completes the response, then req 1 is granted.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously in EXEC.
  - Response: all outputs zero immediately with no clock; after release, state=IDLE, rr_ptr=0, no stale response.
- Counter wrap:
  - Stimulus: with CNT_W=4, run 17 operations.
  - Response: ops_done reads 1.

Source files
------------

// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and helpers for the round-robin adder-sharing arbiter.
package adder_share_arbiter_pkg;

    localparam int N_DEFAULT = 32;
    localparam int MAX_REQ   = 8;
    localparam int PTR_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } pick_t;

    // First valid requester at or above ptr, wrapping modulo num_req.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [PTR_W-1:0]   ptr,
                                      input int                 num_req);
        pick_t res;
        int    j;
        res = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= num_req) j = j - num_req;
            if (i < num_req && !res.found) begin
                if (valid[j]) begin
                    res.found = 1'b1;
                    res.idx   = PTR_W'(j);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/adder_share_arbiter_core.sv
// Combinational adder wrapper: sum, carry out and signed overflow.
module adder_core
    import adder_share_arbiter_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         carry,
    output logic         of
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b};
    assign of = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one adder between NUM_REQ valid/ready requesters.
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int N       = N_DEFAULT,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*N-1:0] req_a,
    input  logic [NUM_REQ*N-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [N-1:0]         rsp_sum,
    output logic                 rsp_carry,
    output logic                 rsp_of,
    output logic                 busy,
    output logic [CNT_W-1:0]     ops_done
);

    state_t               state;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      op_id;
    logic [N-1:0]         op_a;
    logic [N-1:0]         op_b;
    logic [MAX_REQ-1:0]   valid_ext;
    pick_t                pick;
    logic [ID_W-1:0]      grant;
    logic [N-1:0]         core_sum;
    logic                 core_carry;
    logic                 core_of;

    always_comb begin
        valid_ext              = '0;
        valid_ext[NUM_REQ-1:0] = req_valid;
        pick                   = rr_pick(valid_ext, PTR_W'(rr_ptr), NUM_REQ);
        grant                  = ID_W'(pick.idx);
        req_ready              = '0;
        // NOTE: req_ready is combinational, so it is gated by rst_n to stay low during reset.
        if (rst_n && state == ST_IDLE && pick.found) req_ready[grant] = 1'b1;
    end

    adder_core #(.N(N)) u_core (
        .a     (op_a),
        .b     (op_b),
        .sum   (core_sum),
        .carry (core_carry),
        .of    (core_of)
    );

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            op_id     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_of    <= 1'b0;
            busy      <= 1'b0;
            ops_done  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick.found) begin
                        op_a  <= req_a[grant*N +: N];
                        op_b  <= req_b[grant*N +: N];
                        op_id <= grant;
                        state <= ST_EXEC;
                        busy  <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    rsp_sum   <= core_sum;
                    rsp_carry <= core_carry;
                    rsp_of    <= core_of;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ops_done  <= ops_done + CNT_W'(1);
                        // The requester just served drops to lowest priority.
                        rr_ptr    <= (op_id == ID_W'(NUM_REQ - 1)) ? '0 : op_id + ID_W'(1);
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: reference model of grants, timing and sums.
module tb_adder_share_arbiter;

    localparam int N       = 32;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 4;

    typedef enum {M_IDLE, M_EXEC, M_RESP} mstate_t;
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [N-1:0]    sum;
        logic            carry;
        logic            of;
    } rsp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*N-1:0] req_a;
    logic [NUM_REQ*N-1:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [N-1:0]         rsp_sum;
    logic                 rsp_carry;
    logic                 rsp_of;
    logic                 busy;
    logic [CNT_W-1:0]     ops_done;

    adder_share_arbiter #(.N(N), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_of    (rsp_of),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    always #5 clk = ~clk;

    int               n_cmp = 0;
    int               n_bad = 0;
    int               n_grants = 0;
    int               n_rsp = 0;
    rsp_t             sb[$];
    rsp_t             rsp_log[$];
    int               grant_log[$];
    mstate_t          m_state = M_IDLE;
    int               m_ptr = 0;
    logic [CNT_W-1:0] cnt_exp = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic rsp_t model(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] s;
        rsp_t       r;
        s       = {1'b0, a} + {1'b0, b};
        r.id    = ID_W'(id);
        r.sum   = s[N-1:0];
        r.carry = s[N];
        r.of    = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
        return r;
    endfunction

    // Reference model, stepped on the falling edge.
    logic               mon_found;
    int                 mon_g;
    logic [NUM_REQ-1:0] mon_exp_ready;
    rsp_t               obs;
    rsp_t               exp_rsp;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_state = M_IDLE;
            m_ptr   = 0;
            cnt_exp = '0;
        end else begin
            obs = {rsp_id, rsp_sum, rsp_carry, rsp_of};
            check("ops_done", ops_done, cnt_exp);
            case (m_state)
                M_IDLE: begin
                    check("idle_busy", busy, 1'b0);
                    check("idle_rsp_valid", rsp_valid, 1'b0);
                    mon_found = 1'b0;
                    mon_g     = 0;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        int j;
                        j = (m_ptr + k) % NUM_REQ;
                        if (!mon_found && req_valid[j]) begin
                            mon_found = 1'b1;
                            mon_g     = j;
                        end
                    end
                    mon_exp_ready = mon_found ? (NUM_REQ'(1) << mon_g) : '0;
                    check("req_ready", req_ready, mon_exp_ready);
                    if (mon_found) begin
                        sb.push_back(model(mon_g, req_a[mon_g*N +: N], req_b[mon_g*N +: N]));
                        grant_log.push_back(mon_g);
                        n_grants++;
                        m_state = M_EXEC;
                    end
                end
                M_EXEC: begin
                    check("exec_busy", busy, 1'b1);
                    check("exec_rsp_valid", rsp_valid, 1'b0);
                    check("exec_req_ready", req_ready, '0);
                    m_state = M_RESP;
                end
                default: begin
                    check("resp_busy", busy, 1'b1);
                    check("resp_rsp_valid", rsp_valid, 1'b1);
                    check("resp_req_ready", req_ready, '0);
                    if (sb.size() == 0) begin
                        check("sb_depth", sb.size(), 1);
                    end else begin
                        check("rsp", obs, sb[0]);
                        if (rsp_ready) begin
                            exp_rsp = sb.pop_front();
                            rsp_log.push_back(obs);
                            cnt_exp = cnt_exp + CNT_W'(1);
                            m_ptr   = (int'(exp_rsp.id) + 1) % NUM_REQ;
                            n_rsp++;
                            m_state = M_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
    endtask

    task automatic wait_grants(input int target, input string tag);
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            if (n_grants >= target) return;
        end
        check(tag, n_grants, target);
    endtask

    task automatic wait_rsps(input int target, input string tag);
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            if (n_rsp >= target) return;
        end
        check(tag, n_rsp, target);
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            if (m_state == M_IDLE && sb.size() == 0) return;
        end
        check(tag, sb.size(), 0);
    endtask

    task automatic do_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        int g0;
        #1;
        set_req(i, a, b);
        req_valid[i] = 1'b1;
        g0 = n_grants;
        wait_grants(g0 + 1, "op_grant_timeout");
        #1 req_valid[i] = 1'b0;
        wait_idle("op_idle_timeout");
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, '0);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_rsp_id"}, rsp_id, '0);
        check({tag, "_rsp_sum"}, rsp_sum, '0);
        check({tag, "_rsp_carry"}, rsp_carry, 1'b0);
        check({tag, "_rsp_of"}, rsp_of, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_ops_done"}, ops_done, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   g0;
        int   r0;
        int   base;
        int   exp_order[5];
        rsp_t e;

        exp_order = '{0, 1, 2, 3, 0};
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_zero("por");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);

        // Round-robin with every requester continuously valid.
        #1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, N'(i), 32'h10);
        base = rsp_log.size();
        g0   = grant_log.size();
        req_valid = '1;
        wait_grants(n_grants + 5, "rr_grant_timeout");
        #1 req_valid = '0;
        wait_idle("rr_idle_timeout");
        for (int k = 0; k < 5; k++) begin
            check("rr_order", grant_log[g0 + k], exp_order[k]);
            check("rr_sum", rsp_log[base + k].sum, 32'h10 + exp_order[k]);
        end

        // Single operation and overflow/carry corners.
        do_op(0, 32'h5DF92D16, 32'h33C3D1E3);
        e = {2'd0, 32'h91BCFEF9, 1'b0, 1'b1};
        check("single", rsp_log[$], e);
        do_op(2, 32'h93306CEE, 32'h834DC31F);
        e = {2'd2, 32'h167E300D, 1'b1, 1'b1};
        check("neg_of_a", rsp_log[$], e);
        do_op(2, 32'hC0000000, 32'h80000000);
        e = {2'd2, 32'h40000000, 1'b1, 1'b1};
        check("neg_of_b", rsp_log[$], e);
        do_op(1, 32'hFFFFFFFF, 32'h00000001);
        e = {2'd1, 32'h00000000, 1'b1, 1'b0};
        check("carry_only", rsp_log[$], e);
        do_op(3, 32'h7FFFFFFF, 32'h00000001);
        e = {2'd3, 32'h80000000, 1'b0, 1'b1};
        check("pos_of", rsp_log[$], e);

        // Backpressure in RESP while requester 1 waits.
        #1 rsp_ready = 1'b0;
        set_req(0, 32'h0000AAAA, 32'h00005555);
        req_valid[0] = 1'b1;
        wait_grants(n_grants + 1, "bp_grant_timeout");
        #1 req_valid[0] = 1'b0;
        set_req(1, 32'd1234, 32'd4321);
        req_valid[1] = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("bp_busy", busy, 1'b1);
        check("bp_rsp_valid", rsp_valid, 1'b1);
        check("bp_req_ready", req_ready, '0);
        check("bp_sum", rsp_sum, 32'h0000FFFF);
        rsp_ready = 1'b1;
        wait_grants(n_grants + 1, "bp_next_timeout");
        #1 req_valid[1] = 1'b0;
        check("bp_next_grant", grant_log[$], 1);
        wait_idle("bp_idle_timeout");
        check("bp_next_sum", rsp_log[$].sum, 32'd5555);

        // Asynchronous reset while in EXEC.
        #1;
        set_req(3, 32'h11, 32'h22);
        req_valid[3] = 1'b1;
        wait_grants(n_grants + 1, "rst_grant_timeout");
        #1 req_valid[3] = 1'b0;
        #1 rst_n = 1'b0;
        req_valid = '1;
        #1 check_zero("mid_rst");
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("no_stale_rsp", rsp_valid, 1'b0);

        // Counter wrap: 17 operations after reset with a 4-bit counter.
        for (int i = 0; i < NUM_REQ; i++) set_req(i, N'($urandom), N'($urandom));
        g0 = grant_log.size();
        r0 = n_rsp;
        req_valid = '1;
        wait_rsps(r0 + 17, "wrap_timeout");
        #1 req_valid = '0;
        check("ops_done_wrap", ops_done, 4'd1);
        check("first_grant_after_rst", grant_log[g0], 0);
        wait_idle("wrap_idle_timeout");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
